// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with single-cycle handling of divide special cases.
module ex_mdu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            mduop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic            r_sa;
  logic            r_sb;
  logic [W-1:0]    r_opd;
  logic [W:0]      r_hi;
  logic [W-1:0]    r_lo;
  logic            r_done;
  logic [W-1:0]    r_result;

  logic            w_accept;
  logic            w_sa;
  logic            w_sb;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W-1:0]    w_min;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [W-1:0]    w_spec_res;
  logic            w_last;
  logic [W:0]      w_msum;
  logic [2*W-1:0]  w_prod;
  logic [2*W-1:0]  w_prod_s;
  logic [W-1:0]    w_mul_res;
  logic [W:0]      w_shift;
  logic [W:0]      w_diff;
  logic            w_ge;
  logic [W:0]      w_dnext;
  logic [W-1:0]    w_q;
  logic [W-1:0]    w_r;
  logic [W-1:0]    w_div_res;

  // Acceptance decode, operand signedness and magnitudes
  assign w_accept   = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_sa       = opr_a[W-1] & ((mduop == 3'b001) | (mduop == 3'b010) |
                                    (mduop == 3'b100) | (mduop == 3'b110));
  assign w_sb       = opr_b[W-1] & ((mduop == 3'b001) | (mduop == 3'b100) | (mduop == 3'b110));
  assign w_mag_a    = w_sa ? -opr_a : opr_a;
  assign w_mag_b    = w_sb ? -opr_b : opr_b;
  assign w_min      = {1'b1, {(W-1){1'b0}}};
  assign w_div_zero = (opr_b == '0);
  assign w_ovf      = ~mduop[0] & (opr_a == w_min) & (&opr_b);
  assign w_special  = mduop[2] & (w_div_zero | w_ovf);
  assign w_spec_res = w_div_zero ? (mduop[1] ? opr_a : '1) : (mduop[1] ? '0 : w_min);
  assign w_last     = (r_cnt == CW'(W-1));

  // Multiply step: {hi,lo} shifts right as the multiplier bits are consumed
  assign w_msum    = r_hi + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_prod    = {w_msum, r_lo[W-1:1]};
  assign w_prod_s  = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_mul_res = (r_op == 2'b00) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];

  // Restoring divide step: the dividend shifts out of lo as quotient bits shift in
  assign w_shift   = {r_hi[W-1:0], r_lo[W-1]};
  assign w_diff    = w_shift - {1'b0, r_opd};
  assign w_ge      = ~w_diff[W];
  assign w_dnext   = w_ge ? w_diff : w_shift;
  assign w_q       = {r_lo[W-2:0], w_ge};
  assign w_r       = w_dnext[W-1:0];
  assign w_div_res = r_op[1] ? (r_sa ? -w_r : w_r) : ((r_sa ^ r_sb) ? -w_q : w_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opd    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_accept) begin
              r_op  <= mduop[1:0];
              r_sa  <= w_sa;
              r_sb  <= w_sb;
              r_cnt <= '0;
              r_hi  <= '0;
              if (w_special) begin
                r_result <= w_spec_res;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else if (mduop[2]) begin
                r_opd   <= w_mag_b;
                r_lo    <= w_mag_a;
                r_state <= S_DIV;
              end else begin
                r_opd   <= w_mag_a;
                r_lo    <= w_mag_b;
                r_state <= S_MUL;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_MUL: begin
            r_hi  <= {1'b0, w_msum[W:1]};
            r_lo  <= {w_msum[0], r_lo[W-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_cnt    <= '0;
              r_result <= w_mul_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DIV: begin
            r_hi  <= w_dnext;
            r_lo  <= w_q;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_cnt    <= '0;
              r_result <= w_div_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = rst_n & ((r_state == S_MUL) | (r_state == S_DIV) | w_accept);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width, even, >= 8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request from execute stage; sampled only when state is IDLE or DONE.
REQ-005 mduop  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 opr_a  input  DATA_WIDTH  forwarded rs1 operand (multiplicand/dividend).
REQ-007 opr_b  input  DATA_WIDTH  forwarded rs2 operand (multiplier/divisor).
REQ-008 flush  input  1  synchronous abort of the in-flight operation.
REQ-009 busy  output  1  combinational stall request to hazard logic.
REQ-010 done  output  1  registered one-cycle result-valid pulse.
REQ-011 result  output  DATA_WIDTH  registered result; holds until the next done.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-013 Acceptance: start=1 and flush=0 in IDLE or DONE latches mduop, opr_a and opr_b at that edge.
REQ-014 On acceptance with mduop[2]=0, the FSM SHALL go to MUL with iteration counter = 0.
REQ-015 On acceptance with mduop[2]=1 and no special case, the FSM SHALL go to DIV with iteration counter = 0.
REQ-016 Special cases (divisor zero, or signed DIV/REM with opr_a = most-negative and opr_b = all-ones) SHALL go directly to DONE with the result computed in the acceptance cycle.
REQ-017 Divisor zero: DIV/DIVU give all-ones; REM/REMU give opr_a.
REQ-018 Signed overflow: DIV gives the most-negative value; REM gives 0.
REQ-019 MUL/DIV SHALL each perform exactly DATA_WIDTH radix-2 iterations (shift-add / restoring shift-subtract), one per cycle, then go to DONE.
REQ-020 Signed operands SHALL be converted to magnitudes before iterating; the sign SHALL be fixed on the final result.
- MULH: both operands signed; MULHSU: opr_a signed, opr_b unsigned; MULHU, DIVU, REMU: unsigned.
- Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 MUL SHALL return the low DATA_WIDTH bits of the 2*DATA_WIDTH product; MULH/MULHSU/MULHU SHALL return the high DATA_WIDTH bits.
REQ-022 Latency from the acceptance edge to done: DATA_WIDTH+1 cycles normally, 1 cycle for special cases.
REQ-023 done=1 exactly in DONE; result SHALL update on the edge entering DONE.
REQ-024 DONE with no acceptance SHALL return to IDLE; an acceptance in DONE SHALL start back-to-back with no idle cycle.
REQ-025 busy = (state is MUL or DIV) OR (start AND NOT flush AND state is IDLE or DONE).
REQ-026 busy SHALL be 0 in DONE without start, so the pipeline advances while capturing result.
REQ-027 flush=1 in any state SHALL force IDLE at the next edge, suppress done for the aborted operation, and win over a simultaneous start.
REQ-028 result SHALL not change on flush.
REQ-029 start in MUL or DIV SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, counter 0, done 0 and result 0, including in mid-operation.
REQ-031 busy SHALL be 0 while rst_n=0.
REQ-032 After rst_n rises, the first acceptance SHALL be possible on the first clock edge.

Verification (DATA_WIDTH=32)
REQ-033 MUL, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done 33 cycles after acceptance, busy high for 33 cycles including the start cycle.
REQ-034 MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-035 DIV, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU, a=100, b=7 -> 14; REMU same -> 2.
REQ-036 DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; each done 1 cycle after acceptance.
REQ-037 Flush asserted at iteration 10 of a DIV -> IDLE next edge, no done pulse, result unchanged; a start on the next cycle is accepted.
REQ-038 rst_n low mid-MUL -> done=0, result=0, busy=0 immediately; back-to-back start in DONE -> second done exactly 33 cycles after the first.
